// File: rtl/debounce_scheduler.sv
// Time-multiplexed debouncer: one prescaler and one scan FSM serve N_CH channels, with events on a valid/ready port.
// Optional long-press events are enabled by defining DEBOUNCE_SCHED_LONG_PRESS_EN.
module debounce_scheduler_lane #(
  parameter int BOUNCE_TICKS = 4,
  parameter int LONG_TICKS   = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sel,
  input  logic i_sample,
  input  logic i_level,
  output logic o_full,
  output logic o_long
);
  localparam int CW = $clog2(BOUNCE_TICKS + 1);

  logic [CW-1:0] r_cnt;

  assign o_full = (r_cnt == CW'(BOUNCE_TICKS - 1));

  // Accepting and stable samples both restart the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               r_cnt <= '0;
    else if (i_sel) begin
      if ((i_sample != i_level) && !o_full) r_cnt <= r_cnt + CW'(1);
      else                                  r_cnt <= '0;
    end
  end

  if (LONG_TICKS < 1) begin : g_bad_long
    $error("LONG_TICKS must be >= 1");
  end

`ifdef DEBOUNCE_SCHED_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);

  logic [HW-1:0] r_hold;

  assign o_long = i_level && i_sample && (r_hold == HW'(LONG_TICKS - 1));

  // Held at zero while the level is low, which also covers the press cycle;
  // LONG_TICKS marks the long press as already reported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_hold <= '0;
    else if (!i_level)         r_hold <= '0;
    else if (i_sel && i_sample) begin
      if (r_hold == HW'(LONG_TICKS - 1))    r_hold <= HW'(LONG_TICKS);
      else if (r_hold < HW'(LONG_TICKS - 1)) r_hold <= r_hold + HW'(1);
    end
  end
`else
  assign o_long = 1'b0;
`endif

endmodule

module debounce_scheduler #(
  parameter int N_CH         = 4,
  parameter int BOUNCE_TICKS = 4,
  parameter int TICK_DIV     = 12000,
  parameter int LONG_TICKS   = 500,
  localparam int IW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] bouncy_in,
  output logic [N_CH-1:0] debounced_out,
  output logic            event_valid,
  input  logic            event_ready,
  output logic [IW-1:0]   event_ch,
  output logic [1:0]      event_type,
  output logic            overrun,
  input  logic            clr_overrun
);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("N_CH must be in 1..16");
  end
  if (BOUNCE_TICKS < 1) begin : g_bad_bounce
    $error("BOUNCE_TICKS must be >= 1");
  end
  if (TICK_DIV < 2 * N_CH + 2) begin : g_bad_div
    $error("TICK_DIV must be >= 2*N_CH+2");
  end

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [DW-1:0]   r_div;
  logic [N_CH-1:0] r_sync1, r_sync2;

  logic [N_CH-1:0] w_sel, w_full, w_long;
  logic            w_strobe, w_sample, w_level, w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bouncy_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_div <= '0;
    else if (w_strobe) r_div <= '0;
    else               r_div <= r_div + DW'(1);
  end

  assign w_strobe = (r_div == DW'(TICK_DIV - 1));
  assign w_sample = r_sync2[r_idx];
  assign w_level  = debounced_out[r_idx];
  assign w_last   = (r_idx == IW'(N_CH - 1));

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    assign w_sel[g] = (r_state == S_SCAN) && (r_idx == IW'(g));

    debounce_scheduler_lane #(
      .BOUNCE_TICKS (BOUNCE_TICKS),
      .LONG_TICKS   (LONG_TICKS)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_sel    (w_sel[g]),
      .i_sample (r_sync2[g]),
      .i_level  (debounced_out[g]),
      .o_full   (w_full[g]),
      .o_long   (w_long[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      debounced_out <= '0;
      event_valid   <= 1'b0;
      event_ch      <= '0;
      event_type    <= 2'd0;
      overrun       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            r_idx   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if ((w_sample != w_level) && w_full[r_idx]) begin
            debounced_out[r_idx] <= w_sample;
            event_ch             <= r_idx;
            event_type           <= {1'b0, w_sample};
            event_valid          <= 1'b1;
            r_state              <= S_EMIT;
          end else if (w_long[r_idx]) begin
            event_ch    <= r_idx;
            event_type  <= 2'd2;
            event_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_EMIT: begin
          if (event_ready) begin
            event_valid <= 1'b0;
            if (w_last) r_state <= S_IDLE;
            else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= S_SCAN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A tick landing mid-scan is dropped; a drop outranks a same-cycle clear.
      if (w_strobe && (r_state != S_IDLE)) overrun <= 1'b1;
      else if (clr_overrun)                overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Scoreboard bench for debounce_scheduler: expected events are queued as inputs change and popped on each handshake.
module tb_debounce_scheduler;
  localparam int N_CH = 4;
  localparam int BT   = 4;
  localparam int TD   = 16;
  localparam int LT   = 8;
  localparam int LAT  = BT * TD + 2 + N_CH;

  typedef struct packed {
    logic [1:0] ch;
    logic [1:0] typ;
  } evt_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N_CH-1:0] bouncy_in = '0;
  logic [N_CH-1:0] debounced_out;
  logic            event_valid;
  logic            event_ready = 1'b1;
  logic [1:0]      event_ch;
  logic [1:0]      event_type;
  logic            overrun;
  logic            clr_overrun = 1'b0;

  evt_t exp_q[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  debounce_scheduler #(
    .N_CH         (N_CH),
    .BOUNCE_TICKS (BT),
    .TICK_DIV     (TD),
    .LONG_TICKS   (LT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bouncy_in     (bouncy_in),
    .debounced_out (debounced_out),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_ch      (event_ch),
    .event_type    (event_type),
    .overrun       (overrun),
    .clr_overrun   (clr_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: every handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (rst && event_valid && event_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event ch=%0d type=%0d, expected no event", event_ch, event_type);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        if ({event_ch, event_type} !== {e.ch, e.typ}) begin
          errors++;
          $display("FAIL event_match got ch=%0d type=%0d, expected ch=%0d type=%0d",
                   event_ch, event_type, e.ch, e.typ);
        end
      end
      hs_cyc.push_back(cyc);
    end
  end

  task automatic set_in(input logic [N_CH-1:0] v);
    @(posedge clk); #1;
    bouncy_in = v;
  endtask

  task automatic expect_evt(input int ch, input int typ);
    evt_t e;
    e.ch  = 2'(ch);
    e.typ = 2'(typ);
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input int bound, output int lat, output bit ok);
    ok  = 0;
    lat = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (event_valid) begin
        ok  = 1;
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int n0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({debounced_out, event_valid, event_ch, event_type, overrun} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got deb=%b v=%b ch=%0d t=%0d ovr=%b, expected all 0",
                 debounced_out, event_valid, event_ch, event_type, overrun);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    n0 = hs_cyc.size();
    repeat (200) @(negedge clk);
    checks++;
    if (hs_cyc.size() != n0 || debounced_out !== 4'b0000 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet got events=%0d deb=%b ovr=%b, expected 0 0000 0",
               hs_cyc.size() - n0, debounced_out, overrun);
    end
  endtask

  task automatic test_press_release;
    int lat;
    bit ok;
    expect_evt(0, 1);
    set_in(4'b0001);
    wait_valid(LAT, lat, ok);
    checks++;
    if (!ok || lat < (BT - 1) * TD + 2) begin
      errors++;
      $display("FAIL press_latency got %0d cycles (seen=%0d), expected %0d..%0d",
               lat, ok, (BT - 1) * TD + 2, LAT);
    end
    checks++;
    if (debounced_out !== 4'b0001) begin
      errors++;
      $display("FAIL press_level got %b, expected 0001", debounced_out);
    end
    repeat (2 * TD) @(negedge clk);
    expect_evt(0, 0);
    set_in(4'b0000);
    wait_valid(LAT, lat, ok);
    checks++;
    if (!ok || lat < (BT - 1) * TD + 2) begin
      errors++;
      $display("FAIL release_latency got %0d cycles (seen=%0d), expected %0d..%0d",
               lat, ok, (BT - 1) * TD + 2, LAT);
    end
    repeat (2 * TD) @(negedge clk);
    checks++;
    if (debounced_out !== 4'b0000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL release_level got deb=%b pending=%0d, expected 0000 0",
               debounced_out, exp_q.size());
    end
  endtask

  // Two separate 3-sample pulses: the second also fails only if the counter went back to 0.
  task automatic test_glitch;
    int n0;
    n0 = hs_cyc.size();
    for (int k = 0; k < 2; k++) begin
      set_in(4'b0100);
      repeat (3 * TD) @(posedge clk);
      #1;
      bouncy_in = 4'b0000;
      repeat (6 * TD) @(negedge clk);
      checks++;
      if (debounced_out[2] !== 1'b0 || hs_cyc.size() != n0) begin
        errors++;
        $display("FAIL glitch_%0d got deb[2]=%b events=%0d, expected 0 0",
                 k, debounced_out[2], hs_cyc.size() - n0);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    expect_evt(1, 1);
    expect_evt(3, 1);
    set_in(4'b1010);
    wait_drain(LAT + 8, ok);
    repeat (2) @(negedge clk);
    n = hs_cyc.size();
    checks++;
    if (!ok || n < 2) begin
      errors++;
      $display("FAIL pair_drain got pending=%0d, expected 0", exp_q.size());
    end else if (hs_cyc[n-1] - hs_cyc[n-2] > N_CH || hs_cyc[n-1] <= hs_cyc[n-2]) begin
      errors++;
      $display("FAIL pair_gap got %0d cycles, expected 1..%0d", hs_cyc[n-1] - hs_cyc[n-2], N_CH);
    end
    checks++;
    if (debounced_out !== 4'b1010) begin
      errors++;
      $display("FAIL pair_level got %b, expected 1010", debounced_out);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    bit ok;
    bit held;
    @(posedge clk); #1;
    event_ready = 1'b0;
    expect_evt(0, 1);
    set_in(4'b1011);
    wait_valid(LAT, lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_valid got no event_valid in %0d cycles, expected one", LAT);
    end
    held = 1;
    repeat (40) begin
      @(negedge clk);
      if (event_valid !== 1'b1 || event_ch !== 2'd0 || event_type !== 2'd1) held = 0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL stall_hold got v=%b ch=%0d t=%0d, expected held 1 0 1",
               event_valid, event_ch, event_type);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b, expected 1", overrun);
    end
    @(posedge clk); #1;
    event_ready = 1'b1;
    wait_drain(4, ok);
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got ovr=%b pending=%0d, expected 1 0", overrun, exp_q.size());
    end
    @(posedge clk); #1;
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    repeat (3 * TD) @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b, expected 0", overrun);
    end
  endtask

  task automatic test_reset_emit;
    int lat;
    bit ok;
    int n0;
    @(posedge clk); #1;
    event_ready = 1'b0;
    expect_evt(0, 0);
    set_in(4'b1010);
    wait_valid(LAT, lat, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || overrun !== 1'b1 || debounced_out !== 4'b1010) begin
      errors++;
      $display("FAIL emit_setup got v=%b ovr=%b deb=%b, expected 1 1 1010",
               event_valid, overrun, debounced_out);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (event_valid !== 1'b0 || debounced_out !== 4'b0000 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b deb=%b ovr=%b, expected 0 0000 0",
               event_valid, debounced_out, overrun);
    end
    exp_q.delete();
    bouncy_in   = '0;
    event_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    n0 = hs_cyc.size();
    repeat (8 * TD) @(negedge clk);
    checks++;
    if (hs_cyc.size() != n0 || debounced_out !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_quiet got events=%0d deb=%b, expected 0 0000",
               hs_cyc.size() - n0, debounced_out);
    end
  endtask

`ifdef DEBOUNCE_SCHED_LONG_PRESS_EN
  task automatic test_long_press;
    bit ok;
    int n;
    expect_evt(0, 1);
    expect_evt(0, 2);
    set_in(4'b0001);
    wait_drain(LAT + LT * TD + 8, ok);
    repeat (2) @(negedge clk);
    n = hs_cyc.size();
    checks++;
    if (!ok || n < 2) begin
      errors++;
      $display("FAIL long_drain got pending=%0d, expected 0", exp_q.size());
    end else if (hs_cyc[n-1] - hs_cyc[n-2] != LT * TD) begin
      errors++;
      $display("FAIL long_gap got %0d cycles, expected %0d", hs_cyc[n-1] - hs_cyc[n-2], LT * TD);
    end
    repeat (20 * TD) @(negedge clk);
    checks++;
    if (hs_cyc.size() != n) begin
      errors++;
      $display("FAIL long_once got %0d extra events, expected 0", hs_cyc.size() - n);
    end
    expect_evt(0, 0);
    set_in(4'b0000);
    wait_drain(LAT + 8, ok);
  endtask
`endif

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_back_to_back();
    test_backpressure();
    test_reset_emit();
`ifdef DEBOUNCE_SCHED_LONG_PRESS_EN
    test_long_press();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain got %0d pending events, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Time-multiplexed debounce engine for N_CH bouncy inputs (buttons, switches).
- Replaces per-input debouncer instances with one prescaler, one scan FSM and per-channel counters.
- Each channel is processed once per sample tick; qualified edges are emitted as events over a valid/ready interface.
- Sits between board input pins and the UI/control FSMs; also drives per-channel debounced levels.

Parameters:
- N_CH, 4, number of input channels (1..16).
- BOUNCE_TICKS, 4, consecutive differing samples required to accept a new level (>=1).
- TICK_DIV, 12000, clock cycles per sample tick; elaboration error if TICK_DIV < 2*N_CH+2.
- LONG_TICKS, 500, samples held high before a long-press event (used only with LONG_PRESS_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- bouncy_in  in  N_CH  raw asynchronous inputs.
- debounced_out  out  N_CH  accepted stable level per channel.
- event_valid  out  1  event pending.
- event_ready  in  1  consumer accepts event.
- event_ch  out  $clog2(N_CH) (min 1)  channel of event.
- event_type  out  2  0=release, 1=press, 2=long press, 3 unused.
- overrun  out  1  sticky: a sample tick was dropped.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; synchronizers, prescaler, channel counters and idx = 0; FSM = IDLE. A pending event is discarded. Release is synchronous to clk.
- Input sync: each bouncy_in bit passes through a 2-flop synchronizer; sync[i] is the FSM's sample.
- Prescaler: counts 0..TICK_DIV-1 and asserts strobe for one cycle on wrap. It runs continuously, independent of the FSM.
- IDLE: on strobe, idx<=0 and go to SCAN.
- SCAN (one cycle per channel), for channel idx:
  - If sync[idx] != debounced_out[idx] and cnt[idx]==BOUNCE_TICKS-1:
    - debounced_out[idx]<=sync[idx]; cnt<=0.
    - Latch event_ch=idx, event_type = 1 if rising, 0 if falling.
    - Go to EMIT.
  - Else if sync[idx] != debounced_out[idx]: cnt[idx]++.
  - Else: cnt[idx]<=0.
  - With no event: if idx==N_CH-1 go to IDLE, else idx++ and stay in SCAN.
- EMIT:
  - event_valid=1; event_ch and event_type are held stable until the handshake (event_valid && event_ready).
  - debounced_out changes on the same edge that raises event_valid.
  - After the handshake: event_valid<=0; if idx==N_CH-1 go to IDLE, else idx++ and go to SCAN.
  - event_valid never deasserts without a handshake.
- Channel order is strictly ascending within a tick. At most one event per channel per tick.
- Overrun: a strobe arriving while the FSM is not IDLE is dropped and sets overrun<=1. The scan in progress completes unaffected.
  - clr_overrun clears overrun. If a drop and clr_overrun occur on the same cycle, set wins.
- Latency: a clean, stable input edge is reflected in debounced_out within 2 clk + BOUNCE_TICKS ticks + N_CH cycles, provided event_ready is high.
- Counter width: $clog2(BOUNCE_TICKS+1); the counter never exceeds BOUNCE_TICKS-1.
- BOUNCE_TICKS=1: the level is accepted on the first differing sample.

Optional Feature:
- Macro: DEBOUNCE_SCHED_LONG_PRESS_EN.
- Defined:
  - Each channel has a hold counter ($clog2(LONG_TICKS+1) bits), cleared when debounced_out[i] is 0 or on a press event.
  - In each SCAN where the channel is stable high, the hold counter increments.
  - When it reaches LONG_TICKS-1, emit event_type=2 once, through the same EMIT path; the counter then saturates until release.
  - A press and a long press are never emitted for the same channel in the same tick.
- Undefined: the hold counters are not synthesized and event_type is never 2.

Test Plan (N_CH=4, BOUNCE_TICKS=4, TICK_DIV=16, event_ready=1 unless noted):
- Reset held low 3 cycles, then released, inputs 0 -> all outputs 0; no event for 200 cycles.
- bouncy_in[0] 0->1, held -> exactly one event (ch=0, type=1) after the 4th tick, within 4*16+2+4 cycles; debounced_out=4'b0001. Then bouncy_in[0] 1->0, held -> one event (ch=0, type=0).
- bouncy_in[2] high for 3 ticks, then low -> no event; debounced_out[2] stays 0; cnt[2] returns to 0.
- bouncy_in[1] and bouncy_in[3] rise on the same cycle -> events ch=1 then ch=3, both type=1, in consecutive handshakes within one tick.
- Rising edge on ch0 with event_ready=0 for 40 cycles -> event_valid, event_ch and event_type held constant; overrun=1; after the ready handshake, one pulse of clr_overrun -> overrun=0.
- rst driven low while in EMIT -> event_valid, debounced_out and overrun are 0 in the same cycle, without waiting for clk. With DEBOUNCE_SCHED_LONG_PRESS_EN and LONG_TICKS=8: ch0 held high -> press event, then one type=2 event 8 ticks later, none after.
